// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the 16-bit CPU.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables, mux selects and the 2-bit ALUOp consumed by
// the ALU control decoder. Fetch and memory states stretch on mem_ready.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   Opcode          instruction register bits [15:12]
//   mem_ready       memory completes the current access this cycle
//   ALUOp           00 add, 01 sub (BEQ), 10 R-format, 11 I-format
//   ALUSrcA/B       ALU operand selects
//   IorD            memory address select (0 = PC, 1 = ALUOut)
//   MemRead/MemWrite/IRWrite/PCWrite/PCWriteCond  datapath enables
//   PCSource        00 ALU result, 01 ALUOut, 10 jump target
//   RegDst/RegWrite/MemtoReg  register file controls
//   illegal_op      one-cycle pulse in DECODE on an undefined opcode
//   state_o         current state encoding
module multicycle_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    localparam logic [1:0] PC_INC_SEL = 2'b01;
    localparam logic [1:0] OFFSET_SEL = 2'b10;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_WB_R     = 4'd8;
    localparam logic [3:0] S_WB_I     = 4'd9;
    localparam logic [3:0] S_WB_MEM   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;

    localparam logic [3:0] OP_LW = 4'b1100;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // State register; reset forces IDLE, which in turn zeroes every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control outputs, all decoded from the current state.
    always_comb begin
        state_d     = state_q;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = PC_INC_SEL;
                // IR load and PC increment only on the cycle memory delivers.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                // Branch target precompute: PC + sign-extended offset.
                ALUSrcB = OFFSET_SEL;
                case (Opcode)
                    4'b0000, 4'b0001, 4'b0010: state_d = S_EXEC_R;
                    4'b1001, 4'b1010, 4'b1011: state_d = S_EXEC_I;
                    4'b1100, 4'b1101:          state_d = S_MEM_ADDR;
                    4'b0100:                   state_d = S_BRANCH;
                    4'b0101:                   state_d = S_JUMP;
                    default: begin
                        // Undefined opcode retires as a NOP.
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_WB_R;
            end

            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = OFFSET_SEL;
                ALUOp   = 2'b11;
                state_d = S_WB_I;
            end

            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = OFFSET_SEL;
                state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end

            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end

            S_WB_I: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end

            // Encodings 13-15 are unreachable; recover with outputs quiet.
            default: state_d = S_FETCH;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: a queue of expected
// (opcode, mem_ready, state) steps is built per instruction and drained one
// clock at a time, comparing state and the full control word each cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Opcode;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       RegDst;
    logic       RegWrite;
    logic       MemtoReg;
    logic       illegal_op;
    logic [3:0] state_o;

    multicycle_main_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSource   (PCSource),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       regwr;
        logic       m2r;
        logic       ill;
    } ctl_t;

    typedef struct packed {
        logic [3:0] op;
        logic       rdy;
        logic [3:0] st;
    } step_t;

    step_t sb[$];
    int total = 0;
    int bad   = 0;

    // Control word the specification requires in each state.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy, input logic [3:0] op);
        ctl_t c;
        c = '0;
        case (st)
            4'd1: begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
            4'd2: begin
                c.srcb = 2'b10;
                c.ill  = !(op inside {4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd4, 4'd5});
            end
            4'd3:  begin c.srca = 1'b1; c.aluop = 2'b10; end
            4'd4:  begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 2'b11; end
            4'd5:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            4'd6:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            4'd7:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            4'd8:  begin c.regwr = 1'b1; c.regdst = 1'b1; end
            4'd9:  begin c.regwr = 1'b1; end
            4'd10: begin c.regwr = 1'b1; c.m2r = 1'b1; end
            4'd11: begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            4'd12: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t act_ctl();
        ctl_t c;
        c = '{ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
              PCWrite, PCWriteCond, PCSource, RegDst, RegWrite, MemtoReg, illegal_op};
        return c;
    endfunction

    task automatic push(input logic [3:0] op, input logic [3:0] st, input logic rdy);
        step_t s;
        s.op  = op;
        s.rdy = rdy;
        s.st  = st;
        sb.push_back(s);
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp_st);
        total++;
        assert (state_o === exp_st) else begin
            bad++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state_o, exp_st);
        end
    endtask

    task automatic check_ctl(input string tag, input ctl_t exp_c);
        ctl_t a;
        a = act_ctl();
        total++;
        assert (a === exp_c) else begin
            bad++;
            $error("FAIL %s ctl got=%h exp=%h", tag, a, exp_c);
        end
    endtask

    // One queue entry per clock: drive on the falling edge, check 1 time unit later.
    task automatic drain(input string tag);
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk);
            Opcode    = s.op;
            mem_ready = s.rdy;
            #1;
            check_state(tag, s.st);
            check_ctl(tag, exp_ctl(s.st, s.rdy, s.op));
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        Opcode    = 4'b0000;
        #1 rst_n  = 1'b0;
        #1;
        check_state("reset", 4'd0);
        check_ctl("reset", '0);
        #5 rst_n = 1'b1;

        // Reset release: IDLE, then fetch with IRWrite/PCWrite on ready.
        push(4'b0001, 4'd0, 1'b1);
        // R-format
        push(4'b0001, 4'd1, 1'b1); push(4'b0001, 4'd2, 1'b1);
        push(4'b0001, 4'd3, 1'b1); push(4'b0001, 4'd8, 1'b1);
        drain("rtype");

        // LW with two memory wait states
        push(4'b1100, 4'd1, 1'b1); push(4'b1100, 4'd2, 1'b1); push(4'b1100, 4'd5, 1'b1);
        push(4'b1100, 4'd6, 1'b0); push(4'b1100, 4'd6, 1'b0); push(4'b1100, 4'd6, 1'b1);
        push(4'b1100, 4'd10, 1'b1);
        drain("lw");

        // SW with three fetch wait states
        push(4'b1101, 4'd1, 1'b0); push(4'b1101, 4'd1, 1'b0); push(4'b1101, 4'd1, 1'b0);
        push(4'b1101, 4'd1, 1'b1); push(4'b1101, 4'd2, 1'b1); push(4'b1101, 4'd5, 1'b1);
        push(4'b1101, 4'd7, 1'b1);
        drain("sw");

        // BEQ then J
        push(4'b0100, 4'd1, 1'b1); push(4'b0100, 4'd2, 1'b1); push(4'b0100, 4'd11, 1'b1);
        push(4'b0101, 4'd1, 1'b1); push(4'b0101, 4'd2, 1'b1); push(4'b0101, 4'd12, 1'b1);
        drain("beq_j");

        // Undefined opcodes at both ends of the gaps in the map
        push(4'b1111, 4'd1, 1'b1); push(4'b1111, 4'd2, 1'b1);
        push(4'b0011, 4'd1, 1'b1); push(4'b0011, 4'd2, 1'b1);
        push(4'b1000, 4'd1, 1'b1); push(4'b1000, 4'd2, 1'b1);
        drain("illegal");

        // Remaining I-format and R-format opcodes
        push(4'b1001, 4'd1, 1'b1); push(4'b1001, 4'd2, 1'b1);
        push(4'b1001, 4'd4, 1'b1); push(4'b1001, 4'd9, 1'b1);
        push(4'b1010, 4'd1, 1'b1); push(4'b1010, 4'd2, 1'b1);
        push(4'b1010, 4'd4, 1'b1); push(4'b1010, 4'd9, 1'b1);
        push(4'b1011, 4'd1, 1'b1); push(4'b1011, 4'd2, 1'b1);
        push(4'b1011, 4'd4, 1'b1); push(4'b1011, 4'd9, 1'b1);
        push(4'b0000, 4'd1, 1'b1); push(4'b0000, 4'd2, 1'b1);
        push(4'b0000, 4'd3, 1'b1); push(4'b0000, 4'd8, 1'b1);
        drain("iform");

        // SW with a write stall: MemWrite held through the wait
        push(4'b1101, 4'd1, 1'b1); push(4'b1101, 4'd2, 1'b1); push(4'b1101, 4'd5, 1'b1);
        push(4'b1101, 4'd7, 1'b0); push(4'b1101, 4'd7, 1'b0); push(4'b1101, 4'd7, 1'b1);
        drain("sw_stall");

        // Reset dropped mid-write: MemWrite must fall without a clock edge
        push(4'b1101, 4'd1, 1'b1); push(4'b1101, 4'd2, 1'b1); push(4'b1101, 4'd5, 1'b1);
        push(4'b1101, 4'd7, 1'b0);
        drain("sw_rst");
        #2 rst_n = 1'b0;
        #1;
        check_state("async_rst", 4'd0);
        check_ctl("async_rst", '0);
        #4 rst_n = 1'b1;

        // Recovery after reset
        push(4'b0010, 4'd0, 1'b1);
        push(4'b0010, 4'd1, 1'b1); push(4'b0010, 4'd2, 1'b1);
        push(4'b0010, 4'd3, 1'b1); push(4'b0010, 4'd8, 1'b1);
        push(4'b0010, 4'd1, 1'b0);
        drain("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multi-cycle main control FSM for the 16-bit CPU; sits directly upstream of the ALU control decoder and drives its 2-bit ALUOp.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects.
- Stretches fetch and memory states on a single-bit memory ready handshake.

Parameters:
- PC_INC_SEL, 2'b01, ALUSrcB code selecting constant 2 for PC increment.
- OFFSET_SEL, 2'b10, ALUSrcB code selecting the sign-extended immediate.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  4  instruction register bits [15:12]
- mem_ready  in  1  memory completes the current access this cycle
- ALUOp  out  2  00 add (addr/PC), 01 sub (BEQ compare), 10 R-format, 11 I-format
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = const 2, 10 = sign-ext imm
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite, IRWrite  out  1 each
- PCWrite, PCWriteCond  out  1 each
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- RegDst, RegWrite, MemtoReg  out  1 each
- illegal_op  out  1  one-cycle pulse on undefined opcode
- state_o  out  4  current state encoding, for debug and bench

Behaviour:
- Opcode map:
  - 0000/0001/0010 R-format
  - 1001 ADDI, 1010 SUBI, 1011 SLTI
  - 1100 LW, 1101 SW
  - 0100 BEQ, 0101 J
  - all others undefined
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_R=8, WB_I=9, WB_MEM=10, BRANCH=11, JUMP=12.
- Reset (async, rst_n low): state=IDLE; every output 0, including illegal_op. Outputs stay 0 while reset is held.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite = mem_ready (qualified in the same cycle).
  - Hold in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute).
  - Next state: R-format -> EXEC_R; ADDI/SUBI/SLTI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ -> BRANCH; J -> JUMP.
  - Undefined opcode: illegal_op=1 for this cycle only, next state FETCH (instruction treated as NOP).
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_I.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (LW) or MEM_WR (SW). Opcode is stable from the IR during this state.
- MEM_RD: MemRead=1, IorD=1. Hold while mem_ready=0, then -> WB_MEM.
- MEM_WR:
  - MemWrite=1, IorD=1. Hold while mem_ready=0, then -> FETCH.
  - MemWrite stays high for every stalled cycle.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- WB_MEM: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Any output not listed for a state is 0 in that state.
- Outputs are combinational from the state register plus mem_ready/Opcode only where stated above.
- Cycle counts, with no wait states:
  - R-format, I-format, SW: 4
  - LW: 5
  - BEQ, J: 3
  - Undefined opcode: 2
  - Each mem_ready=0 cycle adds 1.
- Reset asserted mid-instruction: immediately IDLE with all outputs 0. No partial write completes after the reset edge.
- Unreachable state encodings 13-15 -> FETCH on the next clock, with all outputs 0 while in them.

Test Plan:
- Reset low, then release with mem_ready=1 -> state_o 0 then 1. All outputs 0 during reset. IRWrite=PCWrite=1 in the first FETCH.
- Opcode 0001, mem_ready=1 -> states 1,2,3,8,1. ALUOp=10 in EXEC_R. RegWrite=RegDst=1 in WB_R.
- Opcode 1100, mem_ready low for 2 cycles in MEM_RD -> states 1,2,5,6,6,6,10,1. MemtoReg=RegWrite=1 only in WB_MEM.
- Opcode 1101, mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles. IRWrite only on the ready cycle. MemWrite high 1 cycle in MEM_WR.
- Opcode 0100 -> ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH. Opcode 0101 -> PCWrite=1, PCSource=10 in JUMP. Both return to FETCH.
- Opcode 1111 -> illegal_op pulses 1 cycle in DECODE, then FETCH. rst_n dropped in MEM_WR -> MemWrite deasserts asynchronously.
